// File: rtl/hex7seg_scan_ctrl_if.sv
// Bundle between a value source (CPU debug values) and the seven-segment scan controller.
// The master drives the values to display; the slave drives the segment and anode pins.
interface hex7seg_scan_ctrl_if #(
    parameter int DIGITS = 6
);
    logic [4*DIGITS-1:0] disp;
    logic [DIGITS-1:0]   blank_mask;
    logic [DIGITS-1:0]   dp;
    logic [7:0]          seg;
    logic [DIGITS-1:0]   AN_SEL;
    logic                frame_done;

    modport master (
        output disp, blank_mask, dp,
        input  seg, AN_SEL, frame_done
    );

    modport slave (
        input  disp, blank_mask, dp,
        output seg, AN_SEL, frame_done
    );
endinterface

// File: rtl/hex7seg_scan_ctrl.sv
// Multiplexed hex seven-segment scanner with internal prescaler, slot-start blanking and
// frame-synchronous shadow capture. Optional leading-zero blanking under HEX7SEG_LZB_EN.
module hex7seg_scan_ctrl #(
    parameter int DIGITS         = 6,
    parameter int PRESCALE       = 131072,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic               sys_Clock,
    input  logic               Reset,
    hex7seg_scan_ctrl_if.slave bus
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0]     CNT_LAST  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0]     BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [7:0]        SEG_OFF   = {8{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_OFF    = {DIGITS{AN_ACTIVE_LOW}};

    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [IW-1:0]       idx_reg, idx_next;
    logic [4*DIGITS-1:0] shadow_disp_reg;
    logic [DIGITS-1:0]   shadow_blank_reg;
    logic [DIGITS-1:0]   shadow_dp_reg;
    logic [7:0]          seg_reg, seg_next;
    logic [DIGITS-1:0]   an_reg, an_next;
    logic                frame_done_reg;

    logic                slot_end;
    logic                capture;
    logic [DIGITS-1:0]   digit_sel;
    logic [3:0]          nibble [DIGITS];
    logic [DIGITS-1:0]   lzb_blank;
    logic [DIGITS-1:0]   blank_eff;
    logic [3:0]          cur_nib;
    logic                cur_blank;
    logic                cur_dp;
    logic                lit;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    assign slot_end = (cnt_reg == CNT_LAST);
    assign capture  = slot_end && (idx_reg == IDX_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign digit_sel[gi] = (idx_reg == IW'(gi));
            assign nibble[gi]    = shadow_disp_reg[4*gi +: 4];
        end
    endgenerate

`ifdef HEX7SEG_LZB_EN
    // zero_run[i]: every digit from DIGITS-1 down to i is a zero nibble without a point.
    logic [DIGITS:1] zero_run;
    assign zero_run[DIGITS] = 1'b1;
    assign lzb_blank[0]     = 1'b0;
    generate
        for (gi = 1; gi < DIGITS; gi++) begin : g_lzb
            assign zero_run[gi]  = zero_run[gi+1] && (nibble[gi] == 4'h0) && !shadow_dp_reg[gi];
            assign lzb_blank[gi] = zero_run[gi];
        end
    endgenerate
`else
    assign lzb_blank = '0;
`endif

    assign blank_eff = shadow_blank_reg | lzb_blank;

    always_comb begin
        cur_nib   = 4'h0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_sel[i]) begin
                cur_nib   = nibble[i];
                cur_blank = blank_eff[i];
                cur_dp    = shadow_dp_reg[i];
            end
        end
    end

    always_comb begin
        cnt_next = slot_end ? '0 : cnt_reg + 1'b1;
        idx_next = idx_reg;
        if (slot_end) begin
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end
        // The first BLANK_CYCLES of each slot keep all anodes off to hide ghosting.
        lit      = (cnt_reg >= BLANK_END) && !cur_blank;
        an_next  = lit ? digit_sel : '0;
        seg_next = lit ? {cur_dp, glyph(cur_nib)} : 8'h00;
    end

    always_ff @(posedge sys_Clock or posedge Reset) begin
        if (Reset) begin
            cnt_reg          <= '0;
            idx_reg          <= '0;
            shadow_disp_reg  <= '0;
            shadow_blank_reg <= '0;
            shadow_dp_reg    <= '0;
            seg_reg          <= SEG_OFF;
            an_reg           <= AN_OFF;
            frame_done_reg   <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            idx_reg <= idx_next;
            if (capture) begin
                shadow_disp_reg  <= bus.disp;
                shadow_blank_reg <= bus.blank_mask;
                shadow_dp_reg    <= bus.dp;
            end
            // XOR with the "off" pattern converts active-high values to pin polarity.
            seg_reg        <= seg_next ^ SEG_OFF;
            an_reg         <= an_next ^ AN_OFF;
            frame_done_reg <= capture;
        end
    end

    assign bus.seg        = seg_reg;
    assign bus.AN_SEL     = an_reg;
    assign bus.frame_done = frame_done_reg;
endmodule

// File: tb/tb_hex7seg_scan_ctrl.sv
// Directed bench for hex7seg_scan_ctrl: DIGITS=6, PRESCALE=8, BLANK_CYCLES=2, low-active pins.
// Build with +define+HEX7SEG_LZB_EN to exercise leading-zero blanking expectations.
module tb_hex7seg_scan_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    hex7seg_scan_ctrl_if #(.DIGITS(6)) bus ();

    hex7seg_scan_ctrl #(
        .DIGITS        (6),
        .PRESCALE      (8),
        .BLANK_CYCLES  (2),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .sys_Clock(clk),
        .Reset    (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Counts edges after Reset release until frame_done; checks the first lit slot on the way.
    task automatic wait_capture(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (n <= 2) check($sformatf("%s an_dark n%0d", tag, n), bus.AN_SEL, 6'h3F);
            if (n == 3) begin
                check($sformatf("%s an_first", tag), bus.AN_SEL, 6'h3E);
                check($sformatf("%s seg_first", tag), bus.seg, 8'hC0);
            end
        end while (!bus.frame_done && n < 200);
        check($sformatf("%s edges", tag), n, 48);
        $display("%s: frame_done after %0d edges", tag, n);
    endtask

    // Checks one full 48-cycle frame, entered at the negedge where frame_done is high.
    // segs holds the expected pin value of digit d at segs[8*d +: 8].
    task automatic check_frame(input string name, input logic [47:0] segs, input logic [5:0] blk,
                               input int chg_k, input logic [23:0] nd, input logic [5:0] nb,
                               input logic [5:0] ndp);
        int c;
        int d;
        logic [5:0] an_exp;
        logic [7:0] seg_exp;
        for (int k = 1; k <= 48; k++) begin
            @(posedge clk);
            @(negedge clk);
            c = (k - 1) % 8;
            d = (k - 1) / 8;
            an_exp  = 6'h3F;
            seg_exp = 8'hFF;
            if (c >= 2 && !blk[d]) begin
                an_exp[d] = 1'b0;
                seg_exp   = segs[8*d +: 8];
            end
            check($sformatf("%s an k%0d", name, k), bus.AN_SEL, an_exp);
            check($sformatf("%s seg k%0d", name, k), bus.seg, seg_exp);
            check($sformatf("%s fd k%0d", name, k), bus.frame_done, (k == 48) ? 1'b1 : 1'b0);
            if (k == chg_k) begin
                bus.disp       = nd;
                bus.blank_mask = nb;
                bus.dp         = ndp;
            end
        end
        $display("frame %s checked", name);
    endtask

    initial begin
        logic [5:0] lzb_a;
        logic [5:0] lzb_b;
`ifdef HEX7SEG_LZB_EN
        lzb_a = 6'b111000;
        lzb_b = 6'b111110;
`else
        lzb_a = 6'b000000;
        lzb_b = 6'b000000;
`endif
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.disp       = 24'h12345F;
        bus.blank_mask = 6'b000000;
        bus.dp         = 6'b000000;
        repeat (3) @(negedge clk);
        check("reset an", bus.AN_SEL, 6'h3F);
        check("reset seg", bus.seg, 8'hFF);
        check("reset fd", bus.frame_done, 1'b0);

        rst = 1'b0;
        wait_capture("first_capture");

        // 12345F; switch to ABCDEF while digit 3 is being scanned.
        check_frame("f1_12345F", 48'hF9_A4_B0_99_92_8E, 6'b000000,
                    26, 24'hABCDEF, 6'b000000, 6'b000000);
        check_frame("f2_ABCDEF", 48'h88_83_C6_A1_86_8E, 6'b000000,
                    10, 24'hABCDEF, 6'b000100, 6'b000001);
        check_frame("f3_blank_dp", 48'h88_83_C6_A1_86_0E, 6'b000100,
                    0, 24'hABCDEF, 6'b000100, 6'b000001);

        // Advance to idx=4, cnt=5, then assert Reset between clock edges.
        repeat (37) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_reset an", bus.AN_SEL, 6'b101111);
        check("pre_reset seg", bus.seg, 8'h83);
        #2 rst = 1'b1;
        #1;
        check("async_reset an", bus.AN_SEL, 6'h3F);
        check("async_reset seg", bus.seg, 8'hFF);
        check("async_reset fd", bus.frame_done, 1'b0);
        bus.disp       = 24'h000A05;
        bus.blank_mask = 6'b000000;
        bus.dp         = 6'b000000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_capture("restart_capture");

        check_frame("f5_000A05", 48'hC0_C0_C0_88_C0_92, lzb_a,
                    10, 24'h000000, 6'b000000, 6'b000000);
        check_frame("f6_zero", 48'hC0_C0_C0_C0_C0_C0, lzb_b,
                    0, 24'h000000, 6'b000000, 6'b000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
